// File: rtl/adv7513_cfg_seq.sv
// ADV7513 configuration sequencer: replays a fixed register table after power-up and
// on hot-plug, services the transmitter interrupt, and retries NACKed transactions.
module adv7513_cfg_seq #(
    parameter logic [6:0]  DEV_ADDR       = 7'h39,
    parameter int unsigned STARTUP_CYCLES = 10_000_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned BACKOFF_CYCLES = 500_000
) (
    input  logic       CLK_50MHZ,
    input  logic       RESET_N,
    input  logic       HDMI_INT_N,
    output logic       I2C_REQ,
    output logic       I2C_RW,
    output logic [6:0] I2C_DEV,
    output logic [7:0] I2C_REG,
    output logic [7:0] I2C_WDATA,
    input  logic       I2C_ACK,
    input  logic       I2C_NACK,
    input  logic [7:0] I2C_RDATA,
    output logic       CFG_DONE,
    output logic       CFG_ERROR,
    output logic       HPD
);

    localparam logic [2:0] ST_STARTUP = 3'd0;
    localparam logic [2:0] ST_TABLE   = 3'd1;
    localparam logic [2:0] ST_ARMED   = 3'd2;
    localparam logic [2:0] ST_INT_RD  = 3'd3;
    localparam logic [2:0] ST_INT_CLR = 3'd4;
    localparam logic [2:0] ST_HPD_RD  = 3'd5;
    localparam logic [2:0] ST_BACKOFF = 3'd6;

    localparam int          TBL_LEN  = 12;
    localparam logic [3:0]  TBL_LAST = 4'd11;
    localparam logic [7:0]  REG_INT  = 8'h96;
    localparam logic [7:0]  REG_HPD  = 8'h42;

    // Entry i lives at bits [16*i +: 16] as {reg, data}; entry 0 is the least significant word.
    localparam logic [16*TBL_LEN-1:0] ROM_INIT = {
        16'h9480, 16'h1630, 16'h1500, 16'hF900,
        16'hE0D0, 16'hA3A4, 16'hA2A4, 16'h9D61,
        16'h9C30, 16'h9AE0, 16'h9803, 16'h4110
    };

    logic [7:0] tbl_addr [16];
    logic [7:0] tbl_data [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rom
            if (gi < TBL_LEN) begin : g_used
                assign tbl_addr[gi] = ROM_INIT[16*gi+8 +: 8];
                assign tbl_data[gi] = ROM_INIT[16*gi   +: 8];
            end else begin : g_pad
                assign tbl_addr[gi] = 8'h00;
                assign tbl_data[gi] = 8'h00;
            end
        end
    endgenerate

    logic [2:0]  state_reg,  state_next;
    logic [31:0] cnt_reg,    cnt_next;
    logic [3:0]  idx_reg,    idx_next;
    logic [31:0] retry_reg,  retry_next;
    logic [7:0]  stat_reg,   stat_next;
    logic        req_reg,    req_next;
    logic        rw_reg,     rw_next;
    logic [7:0]  addr_reg,   addr_next;
    logic [7:0]  wdata_reg,  wdata_next;
    logic        done_reg,   done_next;
    logic        err_reg,    err_next;
    logic        hpd_reg,    hpd_next;
    logic        int_meta_reg;
    logic        int_sync_reg;

    logic        xact_rw;
    logic [7:0]  xact_addr;
    logic [7:0]  xact_data;
    logic        ack_ok;
    logic        ack_bad;

    assign ack_ok  = req_reg & I2C_ACK & ~I2C_NACK;
    assign ack_bad = req_reg & I2C_ACK &  I2C_NACK;

    // Transaction the current state would issue; retries reuse it unchanged.
    always_comb begin
        xact_rw   = 1'b0;
        xact_addr = 8'h00;
        xact_data = 8'h00;
        case (state_reg)
            ST_TABLE: begin
                xact_addr = tbl_addr[idx_reg];
                xact_data = tbl_data[idx_reg];
            end
            ST_INT_RD: begin
                xact_rw   = 1'b1;
                xact_addr = REG_INT;
            end
            ST_INT_CLR: begin
                xact_addr = REG_INT;
                xact_data = stat_reg;
            end
            ST_HPD_RD: begin
                xact_rw   = 1'b1;
                xact_addr = REG_HPD;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        retry_next = retry_reg;
        stat_next  = stat_reg;
        req_next   = req_reg;
        rw_next    = rw_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        hpd_next   = hpd_reg;

        case (state_reg)
            ST_STARTUP: begin
                if (cnt_reg == STARTUP_CYCLES - 1) begin
                    cnt_next   = 32'd0;
                    idx_next   = 4'd0;
                    state_next = ST_TABLE;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end

            ST_BACKOFF: begin
                if (cnt_reg == BACKOFF_CYCLES - 1) begin
                    cnt_next   = 32'd0;
                    idx_next   = 4'd0;
                    state_next = ST_TABLE;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end

            ST_ARMED: begin
                if (!int_sync_reg) begin
                    state_next = ST_INT_RD;
                end
            end

            default: begin
                // Issuing only while REQ is low guarantees a REQ-low cycle between transactions.
                if (!req_reg) begin
                    req_next   = 1'b1;
                    rw_next    = xact_rw;
                    addr_next  = xact_addr;
                    wdata_next = xact_data;
                end else if (ack_bad) begin
                    req_next = 1'b0;
                    if (retry_reg == MAX_RETRY) begin
                        err_next   = 1'b1;
                        done_next  = 1'b0;
                        retry_next = 32'd0;
                        cnt_next   = 32'd0;
                        state_next = ST_BACKOFF;
                    end else begin
                        retry_next = retry_reg + 32'd1;
                    end
                end else if (ack_ok) begin
                    req_next   = 1'b0;
                    retry_next = 32'd0;
                    case (state_reg)
                        ST_TABLE: begin
                            if (idx_reg == TBL_LAST) begin
                                done_next  = 1'b1;
                                err_next   = 1'b0;
                                state_next = ST_ARMED;
                            end else begin
                                idx_next = idx_reg + 4'd1;
                            end
                        end
                        ST_INT_RD: begin
                            stat_next  = I2C_RDATA;
                            state_next = ST_INT_CLR;
                        end
                        ST_INT_CLR: begin
                            state_next = ST_HPD_RD;
                        end
                        ST_HPD_RD: begin
                            hpd_next = I2C_RDATA[6];
                            if (I2C_RDATA[6] && stat_reg[7]) begin
                                // Transmitter lost its settings on the unplug; replay the table.
                                done_next  = 1'b0;
                                idx_next   = 4'd0;
                                state_next = ST_TABLE;
                            end else if (!I2C_RDATA[6]) begin
                                done_next  = 1'b0;
                                state_next = ST_ARMED;
                            end else begin
                                state_next = ST_ARMED;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            int_meta_reg <= 1'b1;
            int_sync_reg <= 1'b1;
        end else begin
            int_meta_reg <= HDMI_INT_N;
            int_sync_reg <= int_meta_reg;
        end
    end

    always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= ST_STARTUP;
            cnt_reg   <= 32'd0;
            idx_reg   <= 4'd0;
            retry_reg <= 32'd0;
            stat_reg  <= 8'h00;
            req_reg   <= 1'b0;
            rw_reg    <= 1'b0;
            addr_reg  <= 8'h00;
            wdata_reg <= 8'h00;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            hpd_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            retry_reg <= retry_next;
            stat_reg  <= stat_next;
            req_reg   <= req_next;
            rw_reg    <= rw_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            hpd_reg   <= hpd_next;
        end
    end

    assign I2C_REQ   = req_reg;
    assign I2C_RW    = rw_reg;
    assign I2C_DEV   = DEV_ADDR;
    assign I2C_REG   = addr_reg;
    assign I2C_WDATA = wdata_reg;
    assign CFG_DONE  = done_reg;
    assign CFG_ERROR = err_reg;
    assign HPD       = hpd_reg;

endmodule
